dm_wait_ram: RTL and testbench
==============================

// Module: dm_wait_ram
// PURPOSE
//   Word-organised data memory for the MIPS pipeline, with byte-enable writes and a valid/ready request handshake.
//   Response latency is configurable, so the CPU stall/forwarding logic can be exercised against a slow memory.
//   Sits between the CPU data port and the bench. Replaces the zero-latency array model.
//   Clears its contents with a sequencer after reset, and flags accesses outside its window.
// PARAMETERS
//   BASE_ADDR   32'h0000_0000  byte address of word 0
//   DEPTH       4096           number of 32-bit words (power of 2, >= 2)
//   LAT         0              extra wait cycles before response (0..15)
// PORTS
//   clk         in   1   clock, rising edge
//   reset       in   1   synchronous, active-high
//   req_valid   in   1   request present
//   req_ready   out  1   block can accept request this cycle
//   req_addr    in   32  byte address; bits [1:0] ignored
//   req_byteen  in   4   lane write enables; 4'b0000 = read
//   req_wdata   in   32  write data, lane-aligned (lane i = bits [8i+7:8i])
//   req_pc      in   32  PC of issuing instruction (trace only)
//   resp_valid  out  1   one-cycle response strobe
//   resp_rdata  out  32  read data; merged word for writes
//   resp_err    out  1   address outside [BASE_ADDR, BASE_ADDR+4*DEPTH)
// BEHAVIOUR
//   - Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, state=CLEAR, clr_idx=0.
//   - FSM states:
//     CLEAR: writes 0 to word clr_idx, then increments it. After word DEPTH-1 -> IDLE. Takes exactly DEPTH cycles.
//     IDLE: req_ready=1. The request is accepted on the edge where req_valid&&req_ready.
//       Address, byteen, wdata and pc are latched. Next state is WAIT if LAT>0, else RESP.
//     WAIT: a counter loads LAT-1 and decrements. At 0 -> RESP.
//     RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
//   - One request outstanding at a time; req_ready=0 in CLEAR/WAIT/RESP. Request accepted at edge t -> resp_valid high in cycle t+1+LAT.
//   - Back-to-back: a request is first acceptable in the cycle after RESP. Throughput is 1 request per LAT+2 cycles.
//   - Index = (addr-BASE_ADDR)>>2, computed with 32-bit unsigned wrap. Index >= DEPTH -> resp_err=1, no array write, resp_rdata=0.
//   - Read: resp_rdata = mem[idx] sampled at the RESP edge.
//   - Write:
//     merged = mem[idx] with enabled lanes replaced by req_wdata lanes; disabled lanes are unchanged.
//     The write commits to the array on the RESP-entry edge. resp_rdata = merged.
//   - byteen is not checked for alignment (any of the 16 patterns is legal).
//   - req_* inputs are ignored outside IDLE. They need not be held after acceptance.
//   - Reset asserted in any state, including mid-WAIT or mid-CLEAR: the pending request is dropped, no write occurs, and the FSM restarts CLEAR at idx 0.
// CONFIGURATION
//   DM_WAIT_RAM_TRACE_EN defined:
//     On each committed write, print $display("%d@%h: *%h <= %h", $time, pc, word_addr, merged).
//     word_addr = BASE_ADDR + 4*idx. Error accesses print "%d@%h: DM ERR %h".
//   DM_WAIT_RAM_TRACE_EN undefined: no $display, and the logic is otherwise identical.
// STRUCTURE
//   - Package mips_mem_pkg:
//     dm_state_t enum {CLEAR, IDLE, WAIT, RESP}
//     BYTEEN_NONE=4'b0000, BYTEEN_WORD=4'b1111
//     LANE_W=8, lane index constants
//   - Sub-module dm_byte_merge (combinational): old word, wdata, byteen -> merged word. Instantiated once.
// TESTING
//   - Reset, then poll: req_ready=0 for exactly DEPTH cycles after reset drops. A read of any address afterwards -> rdata=0, err=0.
//   - LAT=3: write addr 0x10, byteen 1111, data 0xDEADBEEF accepted at edge t -> resp_valid only in cycle t+4. A following read of 0x10 -> 0xDEADBEEF.
//   - Byte merge: word 0x11223344 at 0x20, then write byteen 0100 with wdata 0x00AA0000 -> read gives 0x11AA3344.
//     sh variant: byteen 1100 with wdata 0xBEEF0000 -> 0xBEEF3344.
//   - Out of range: addr BASE_ADDR+4*DEPTH with byteen 1111 -> resp_err=1, rdata=0. Re-read of word 0 is unchanged.
//     addr BASE_ADDR-4 (wraps) -> resp_err=1.
//   - Reset mid-WAIT (LAT=5, reset in wait cycle 2): no resp_valid, and the target word reads 0 after CLEAR completes.
//   - With DM_WAIT_RAM_TRACE_EN: one trace line per committed write with the correct pc/addr/merged data. None for reads.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory models.
// The FSM state type is exported so the state can be observed on a debug port.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } dm_state_t;

  localparam logic [3:0] BYTEEN_NONE = 4'b0000;
  localparam logic [3:0] BYTEEN_WORD = 4'b1111;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int LANE0     = 0;
  localparam int LANE1     = 1;
  localparam int LANE2     = 2;
  localparam int LANE3     = 3;

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational lane merge: each enabled lane takes wdata, every other lane keeps the old word.
module dm_byte_merge
  import mips_mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (byteen[i]) merged[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/dm_wait_ram.sv
// Word-organised data memory with byte-enable writes, a valid/ready request port, LAT wait cycles
// and a post-reset clear sequencer. Define DM_WAIT_RAM_TRACE_EN to print a line per committed write.
module dm_wait_ram
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          LAT       = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output dm_state_t   dbg_state
);

  // Handshake: a request transfers on the rising edge where req_valid && req_ready; req_ready is
  // high only in IDLE, so at most one request is in flight and resp_valid pulses once per request.

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  dm_state_t   state, state_nxt;
  logic [AW-1:0] clr_idx;
  logic [3:0]  wait_cnt;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_byteen;
  logic [31:0] mem [DEPTH];

  logic        accept, enter_resp, addr_err;
  logic [31:0] cur_addr, cur_wdata, word_off, old_word, merged;
  logic [3:0]  cur_byteen;
  logic [AW-1:0] idx;

  assign accept     = req_valid && (state == IDLE);
  assign enter_resp = (state == WAIT && wait_cnt == 4'd0) || (accept && LAT == 0);

  // With LAT=0 the access completes on the accept edge itself, so the live request is used.
  assign cur_addr   = (state == IDLE) ? req_addr   : lat_addr;
  assign cur_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;
  assign cur_byteen = (state == IDLE) ? req_byteen : lat_byteen;

  assign word_off = (cur_addr - BASE_ADDR) >> 2;
  assign addr_err = (word_off >= 32'(DEPTH));
  assign idx      = word_off[AW-1:0];
  assign old_word = mem[idx];

  dm_byte_merge u_merge (
    .old_word (old_word),
    .wdata    (cur_wdata),
    .byteen   (cur_byteen),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR: if (clr_idx == AW'(DEPTH - 1)) state_nxt = IDLE;
      IDLE:  if (accept) state_nxt = (LAT > 0) ? WAIT : RESP;
      WAIT:  if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    dbg_state  = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_idx    <= '0;
      wait_cnt   <= 4'd0;
      lat_addr   <= 32'd0;
      lat_wdata  <= 32'd0;
      lat_byteen <= BYTEEN_NONE;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
      if (accept) begin
        lat_addr   <= req_addr;
        lat_wdata  <= req_wdata;
        lat_byteen <= req_byteen;
        wait_cnt   <= LAT_M1;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_resp) begin
        resp_rdata <= addr_err ? 32'd0 : merged;
        resp_err   <= addr_err;
      end
    end
  end

  // Single write port shared by the clear sequencer and committed writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) mem[clr_idx] <= 32'd0;
      else if (enter_resp && !addr_err && cur_byteen != BYTEEN_NONE) mem[idx] <= merged;
    end
  end

`ifdef DM_WAIT_RAM_TRACE_EN
  logic [31:0] lat_pc, cur_pc;

  always_ff @(posedge clk) begin
    if (reset)       lat_pc <= 32'd0;
    else if (accept) lat_pc <= req_pc;
  end

  assign cur_pc = (state == IDLE) ? req_pc : lat_pc;

  always_ff @(posedge clk) begin
    if (!reset && enter_resp) begin
      if (addr_err)
        $display("%d@%h: DM ERR %h", $time, cur_pc, cur_addr);
      else if (cur_byteen != BYTEEN_NONE)
        $display("%d@%h: *%h <= %h", $time, cur_pc, BASE_ADDR + (32'(idx) << 2), merged);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

endmodule

// File: tb/tb_dm_wait_ram.sv
// Directed bench for dm_wait_ram: three instances (LAT=3, LAT=5 with non-zero base, LAT=0)
// checked against hand-computed values with immediate assertions.
module tb_dm_wait_ram;
  import mips_mem_pkg::*;

  localparam int NDUT = 3;
  localparam int DEPTH_D [NDUT] = '{64, 16, 16};
  localparam int LAT_D   [NDUT] = '{3, 5, 0};

  logic        clk;
  logic        reset      [NDUT];
  logic        req_valid  [NDUT];
  logic        req_ready  [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [3:0]  req_byteen [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic [31:0] req_pc     [NDUT];
  logic        resp_valid [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        resp_err   [NDUT];
  dm_state_t   dbg_state  [NDUT];

  int tests = 0;
  int fails = 0;

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  dm_wait_ram #(.BASE_ADDR(32'h0000_0000), .DEPTH(64), .LAT(3)) dut0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .req_byteen(req_byteen[0]), .req_wdata(req_wdata[0]),
    .req_pc(req_pc[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .dbg_state(dbg_state[0])
  );

  dm_wait_ram #(.BASE_ADDR(32'h0000_1000), .DEPTH(16), .LAT(5)) dut1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .req_byteen(req_byteen[1]), .req_wdata(req_wdata[1]),
    .req_pc(req_pc[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .dbg_state(dbg_state[1])
  );

  dm_wait_ram #(.BASE_ADDR(32'h0000_0000), .DEPTH(16), .LAT(0)) dut2 (
    .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .req_byteen(req_byteen[2]), .req_wdata(req_wdata[2]),
    .req_pc(req_pc[2]), .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2]), .dbg_state(dbg_state[2])
  );

  // ---- scoreboard check ----
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- driver: one request, called and returning at a falling edge ----
  task automatic do_req(input int d, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] pc,
                        output logic [31:0] rd, output logic err, output int lat);
    int n;
    n = 0;
    while (!req_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(req_ready[d]), 32'd1);
    req_valid[d]  = 1'b1;
    req_addr[d]   = addr;
    req_byteen[d] = be;
    req_wdata[d]  = wd;
    req_pc[d]     = pc;
    @(posedge clk);
    #1;
    // Scramble the inputs so a design that fails to latch them is caught.
    req_valid[d]  = 1'b0;
    req_addr[d]   = 32'hFFFF_FFF0;
    req_byteen[d] = 4'hF;
    req_wdata[d]  = 32'h0BAD_0BAD;
    lat = 0;
    rd  = 32'hX;
    err = 1'bX;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (resp_valid[d]) begin
        lat = i;
        rd  = resp_rdata[d];
        err = resp_err[d];
        break;
      end
    end
    check("ready_in_resp", 32'(req_ready[d]), 32'd0);
    @(negedge clk);
    check("resp_pulse", 32'(resp_valid[d]), 32'd0);
    check("ready_after_resp", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic txn(input string tag, input int d, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    int          lat;
    do_req(d, addr, be, wd, 32'h0040_0000 + addr, rd, err, lat);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_lat"}, 32'(lat), 32'(LAT_D[d] + 1));
  endtask

  // ---- directed sequence ----
  initial begin
    int  cnt  [NDUT];
    bit  done [NDUT];
    int  nresp;

    for (int d = 0; d < NDUT; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = 32'd0;
      req_byteen[d] = 4'd0; req_wdata[d] = 32'd0; req_pc[d] = 32'd0;
      cnt[d] = 0; done[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready[0]), 32'd0);
    check("rst_valid", 32'(resp_valid[0]), 32'd0);
    check("rst_rdata", resp_rdata[0], 32'd0);
    check("rst_err", 32'(resp_err[0]), 32'd0);
    check("rst_state", 32'(dbg_state[0]), 32'(CLEAR));

    // req_ready must stay low for exactly DEPTH cycles after reset drops
    for (int d = 0; d < NDUT; d++) reset[d] = 1'b0;
    for (int i = 0; i < 200; i++) begin
      for (int d = 0; d < NDUT; d++) begin
        if (!done[d]) begin
          if (!req_ready[d]) cnt[d]++;
          else done[d] = 1'b1;
        end
      end
      if (done[0] && done[1] && done[2]) break;
      @(negedge clk);
    end
    check("clear_cycles_d0", 32'(cnt[0]), 32'd64);
    check("clear_cycles_d1", 32'(cnt[1]), 32'd16);
    check("clear_cycles_d2", 32'(cnt[2]), 32'd16);
    check("idle_state", 32'(dbg_state[0]), 32'(IDLE));

    // LAT=3 instance
    txn("clr_rd40", 0, 32'h40, 4'b0000, 32'h0, 32'h0, 1'b0);
    txn("clr_rdfc", 0, 32'hFC, 4'b0000, 32'h0, 32'h0, 1'b0);
    txn("wr_10", 0, 32'h10, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    txn("rd_10", 0, 32'h10, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn("rd_13", 0, 32'h13, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn("wr_20", 0, 32'h20, 4'b1111, 32'h1122_3344, 32'h1122_3344, 1'b0);
    txn("sb_20", 0, 32'h20, 4'b0100, 32'h00AA_0000, 32'h11AA_3344, 1'b0);
    txn("rd_20a", 0, 32'h20, 4'b0000, 32'h0, 32'h11AA_3344, 1'b0);
    txn("wr_20b", 0, 32'h20, 4'b1111, 32'h1122_3344, 32'h1122_3344, 1'b0);
    txn("sh_20", 0, 32'h20, 4'b1100, 32'hBEEF_0000, 32'hBEEF_3344, 1'b0);
    txn("rd_20b", 0, 32'h20, 4'b0000, 32'h0, 32'hBEEF_3344, 1'b0);
    txn("sb_10", 0, 32'h10, 4'b0001, 32'h1234_56AA, 32'hDEAD_BEAA, 1'b0);
    txn("wr_00", 0, 32'h00, 4'b1111, 32'h5566_7788, 32'h5566_7788, 1'b0);
    txn("oor_hi", 0, 32'h100, 4'b1111, 32'hFFFF_FFFF, 32'h0, 1'b1);
    txn("rd_00", 0, 32'h00, 4'b0000, 32'h0, 32'h5566_7788, 1'b0);
    txn("oor_wrap", 0, 32'hFFFF_FFFC, 4'b1111, 32'h1234_5678, 32'h0, 1'b1);
    txn("rd_fc", 0, 32'hFC, 4'b0000, 32'h0, 32'h0, 1'b0);

    // LAT=5 instance, BASE 0x1000, DEPTH 16
    txn("b_wr_08", 1, 32'h1008, 4'b1111, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0);
    txn("b_rd_08", 1, 32'h1008, 4'b0000, 32'h0, 32'hA5A5_A5A5, 1'b0);
    txn("b_oor_hi", 1, 32'h1040, 4'b0000, 32'h0, 32'h0, 1'b1);
    txn("b_oor_lo", 1, 32'h0FFC, 4'b1111, 32'h7777_7777, 32'h0, 1'b1);
    txn("b_rd_00", 1, 32'h1000, 4'b0000, 32'h0, 32'h0, 1'b0);

    // reset in the second wait cycle: no response, no write, clear restarts
    req_valid[1] = 1'b1; req_addr[1] = 32'h1004; req_byteen[1] = 4'b1111;
    req_wdata[1] = 32'hCAFE_BABE; req_pc[1] = 32'h0040_1004;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    check("mid_wait_state", 32'(dbg_state[1]), 32'(WAIT));
    @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    check("mid_wait_rst_state", 32'(dbg_state[1]), 32'(CLEAR));
    check("mid_wait_rst_valid", 32'(resp_valid[1]), 32'd0);
    nresp = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid[1]) nresp++;
    end
    check("mid_wait_no_resp", 32'(nresp), 32'd0);
    txn("b_rd_04", 1, 32'h1004, 4'b0000, 32'h0, 32'h0, 1'b0);
    txn("b_rd_08c", 1, 32'h1008, 4'b0000, 32'h0, 32'h0, 1'b0);

    // LAT=0 instance, back-to-back
    txn("z_wr_08", 2, 32'h08, 4'b1111, 32'h0102_0304, 32'h0102_0304, 1'b0);
    txn("z_sb_08", 2, 32'h08, 4'b0010, 32'h0000_EE00, 32'h0102_EE04, 1'b0);
    txn("z_rd_08", 2, 32'h08, 4'b0000, 32'h0, 32'h0102_EE04, 1'b0);
    txn("z_oor", 2, 32'h40, 4'b1111, 32'h1, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
